// File: rtl/display_scan_scheduler_if.sv
// Bus between the display scan scheduler and its pattern source / board pins.
// The slave side is the scheduler; the master side drives patterns and observes the pins.
interface display_scan_scheduler_if;
  logic        en;
  logic [27:0] dig_seg_i;
  logic [34:0] col_pat_i;
  logic        upd_i;
  logic        upd_ack_o;
  logic [6:0]  seg_o;
  logic [3:0]  dig_n_o;
  logic [6:0]  row_o;
  logic [4:0]  col_n_o;
  logic        frame_o;

  modport slave (
    input  en, dig_seg_i, col_pat_i, upd_i,
    output upd_ack_o, seg_o, dig_n_o, row_o, col_n_o, frame_o
  );

  modport master (
    output en, dig_seg_i, col_pat_i, upd_i,
    input  upd_ack_o, seg_o, dig_n_o, row_o, col_n_o, frame_o
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan of a 4-digit 7-segment display and a 7x5 LED matrix from
// double-buffered shadow patterns. Define DISP_BLANKING_EN to add dark time between slots.
module display_scan_scheduler #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  display_scan_scheduler_if.slave bus
);

  localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [4:0]    SLOT_LAST  = 5'd19;
  localparam logic [2:0]    COL_LAST   = 3'd4;

  if ((CLK_DIV < 2) || (BLANK_CYC < 1) || (BLANK_CYC >= CLK_DIV)) begin : g_bad_params
    $error("display_scan_scheduler: CLK_DIV must be >= 2 and 1 <= BLANK_CYC < CLK_DIV");
  end

`ifdef DISP_BLANKING_EN
  localparam int            BW         = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  logic [BW-1:0] blank_q, blank_d;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    slot_q, slot_d;
  logic [1:0]    dig_q, dig_d;
  logic [2:0]    col_q, col_d;

  logic [6:0]    seg_sh_q [4];
  logic [6:0]    seg_sh_d [4];
  logic [6:0]    col_sh_q [5];
  logic [6:0]    col_sh_d [5];

  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_n_q, dig_n_d;
  logic [6:0]    row_q, row_d;
  logic [4:0]    col_n_q, col_n_d;
  logic          ack_q, ack_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          advance;
  logic          boundary;
  logic          load;

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      slot_q   <= '0;
      dig_q    <= '0;
      col_q    <= '0;
`ifdef DISP_BLANKING_EN
      blank_q  <= '0;
`endif
      seg_sh_q <= '{default: 7'h7F};
      col_sh_q <= '{default: 7'h00};
      seg_q    <= 7'h7F;
      dig_n_q  <= 4'hF;
      row_q    <= 7'h00;
      col_n_q  <= 5'h1F;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      dig_q    <= dig_d;
      col_q    <= col_d;
`ifdef DISP_BLANKING_EN
      blank_q  <= blank_d;
`endif
      seg_sh_q <= seg_sh_d;
      col_sh_q <= col_sh_d;
      seg_q    <= seg_d;
      dig_n_q  <= dig_n_d;
      row_q    <= row_d;
      col_n_q  <= col_n_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    slot_d   = slot_q;
    dig_d    = dig_q;
    col_d    = col_q;
`ifdef DISP_BLANKING_EN
    blank_d  = blank_q;
`endif
    seg_sh_d = seg_sh_q;
    col_sh_d = col_sh_q;
    advance  = 1'b0;
    boundary = 1'b0;
    load     = 1'b0;
    seg_d    = 7'h7F;
    dig_n_d  = 4'hF;
    row_d    = 7'h00;
    col_n_d  = 5'h1F;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_SHOW;
          presc_d = '0;
          slot_d  = '0;
          dig_d   = '0;
          col_d   = '0;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          presc_d = '0;
`ifdef DISP_BLANKING_EN
          state_d = ST_BLANK;
          blank_d = '0;
`else
          advance = 1'b1;
`endif
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
`ifdef DISP_BLANKING_EN
      ST_BLANK: begin
        if (blank_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          advance = 1'b1;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Digit and column indices wrap independently; the slot counter only marks the frame.
    if (advance) begin
      slot_d   = (slot_q == SLOT_LAST) ? 5'd0 : slot_q + 5'd1;
      dig_d    = dig_q + 2'd1;
      col_d    = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
      boundary = (slot_q == SLOT_LAST);
    end

    if (!bus.en) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      slot_d   = '0;
      dig_d    = '0;
      col_d    = '0;
`ifdef DISP_BLANKING_EN
      blank_d  = '0;
`endif
      boundary = 1'b0;
    end

    // The ack cycle itself is ignored so a held request is not taken twice.
    load = bus.upd_i && !ack_q && ((state_q == ST_IDLE) || boundary);
    if (load) begin
      for (int i = 0; i < 4; i++) seg_sh_d[i] = bus.dig_seg_i[7*i +: 7];
      for (int i = 0; i < 5; i++) col_sh_d[i] = bus.col_pat_i[7*i +: 7];
    end

    // Outputs follow the next state so slot 0 after a boundary load shows the new data.
    if (state_d == ST_SHOW) begin
      dig_n_d = ~(4'b0001 << dig_d);
      seg_d   = seg_sh_d[dig_d];
      col_n_d = ~(5'b00001 << col_d);
      row_d   = col_sh_d[col_d];
    end

    ack_d   = load;
    frame_d = boundary;
  end

  assign bus.seg_o     = seg_q;
  assign bus.dig_n_o   = dig_n_q;
  assign bus.row_o     = row_q;
  assign bus.col_n_o   = col_n_q;
  assign bus.upd_ack_o = ack_q;
  assign bus.frame_o   = frame_q;

endmodule
